// File: rtl/mem_issue_queue_if.sv
`default_nettype none
// DecoderTypes micro-op definitions and the handshake bundle between upstream, queue and memory pipeline.

package DecoderTypes;
  typedef enum logic [1:0] {
    m_ld      = 2'd0,
    m_st      = 2'd1,
    m_clflush = 2'd2
  } mem_op_e;

  typedef struct packed {
    mem_op_e     op;
    logic [31:0] src0;
    logic [31:0] src1;
  } micro_op_t;
endpackage

interface mem_issue_queue_if #(
  parameter int DEPTH = 4
);
  import DecoderTypes::*;

  logic                   enq_valid;
  micro_op_t              enq_mop;
  logic                   enq_ready;
  logic                   mem_busy;
  logic                   flush;
  logic                   issue_ready;
  micro_op_t              issue_mop;
  logic [$clog2(DEPTH):0] count;
  logic [31:0]            issued_cnt;

  modport master (
    output enq_valid, enq_mop, mem_busy, flush,
    input  enq_ready, issue_ready, issue_mop, count, issued_cnt
  );

  modport slave (
    input  enq_valid, enq_mop, mem_busy, flush,
    output enq_ready, issue_ready, issue_mop, count, issued_cnt
  );
endinterface

`default_nettype wire

// File: rtl/mem_issue_queue.sv
`default_nettype none
// mem_issue_queue: in-order circular issue queue feeding the memory pipeline.
// Define MEM_ISSUE_QUEUE_BYPASS_EN for same-cycle issue of an enqueue into an empty queue.

module mem_issue_queue #(
  parameter int DEPTH = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mem_issue_queue_if.slave bus
);
  import DecoderTypes::*;

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  micro_op_t     entries [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   occ;
  logic [31:0]   issued_total;
  logic          bypass;
  logic          queue_issue;
  logic          do_enq;

  always_comb begin
    bypass = 1'b0;
`ifdef MEM_ISSUE_QUEUE_BYPASS_EN
    bypass = (occ == '0) && bus.enq_valid && !bus.mem_busy && !bus.flush;
`endif
    queue_issue = (occ != '0) && !bus.mem_busy && !bus.flush;
    // A bypassed micro-op goes straight out and never occupies a slot.
    do_enq      = bus.enq_valid && (occ != FULL_COUNT) && !bus.flush && !bypass;
  end

  assign bus.enq_ready   = (occ != FULL_COUNT);
  assign bus.issue_ready = queue_issue || bypass;
  assign bus.count       = occ;
  assign bus.issued_cnt  = issued_total;
`ifdef MEM_ISSUE_QUEUE_BYPASS_EN
  assign bus.issue_mop   = bypass ? bus.enq_mop : entries[rd_ptr];
`else
  assign bus.issue_mop   = entries[rd_ptr];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      occ          <= '0;
      issued_total <= '0;
    end else begin
      if (queue_issue || bypass) begin
        issued_total <= issued_total + 32'd1;
      end
      if (bus.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        occ    <= '0;
      end else begin
        if (queue_issue) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (do_enq) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        case ({do_enq, queue_issue})
          2'b10:   occ <= occ + (AW+1)'(1);
          2'b01:   occ <= occ - (AW+1)'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      entries[wr_ptr] <= bus.enq_mop;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_issue_queue.sv
`default_nettype none
// Self-checking bench for mem_issue_queue: directed vector table, corner sequences, randomized run vs queue model.

module tb_mem_issue_queue;
  import DecoderTypes::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef MEM_ISSUE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_issue_queue_if #(.DEPTH(DEPTH)) bus ();

  mem_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  micro_op_t   mq[$];
  logic [31:0] m_issued = '0;

  logic        obs_er;
  logic        obs_ir;
  logic [CW-1:0] obs_cnt;
  logic [31:0] obs_iss;
  micro_op_t   obs_mop;

  typedef struct {
    logic        ev;
    logic        busy;
    logic        fl;
    logic [31:0] src0;
    logic        exp_er;
    logic        exp_ir;
    int          exp_cnt;
    logic [31:0] exp_src0;
    logic [31:0] exp_issued;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic micro_op_t mk(input mem_op_e op, input logic [31:0] s0, input logic [31:0] s1);
    micro_op_t m;
    m.op   = op;
    m.src0 = s0;
    m.src1 = s1;
    return m;
  endfunction

  // One clock cycle: drive at negedge, sample and compare to the queue model, then retire at posedge.
  task automatic cycle(input logic ev, input micro_op_t mop, input logic busy, input logic fl);
    logic      exp_er;
    logic      exp_ir;
    logic      byp;
    micro_op_t exp_mop;
    @(negedge clk);
    bus.enq_valid = ev;
    bus.enq_mop   = mop;
    bus.mem_busy  = busy;
    bus.flush     = fl;
    #1;
    obs_er  = bus.enq_ready;
    obs_ir  = bus.issue_ready;
    obs_cnt = bus.count;
    obs_iss = bus.issued_cnt;
    obs_mop = bus.issue_mop;
    exp_er  = (mq.size() != DEPTH);
    byp     = BYP && (mq.size() == 0) && ev && !busy && !fl;
    exp_ir  = ((mq.size() != 0) && !busy && !fl) || byp;
    exp_mop = byp ? mop : ((mq.size() != 0) ? mq[0] : mop);
    check("model_enq_ready", obs_er, exp_er);
    check("model_issue_ready", obs_ir, exp_ir);
    check("model_count", obs_cnt, mq.size());
    check("model_issued_cnt", obs_iss, m_issued);
    if (exp_ir) check("model_issue_mop", obs_mop, exp_mop);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (exp_ir && !byp) void'(mq.pop_front());
      if (ev && exp_er && !byp) mq.push_back(mop);
    end
    if (exp_ir) m_issued = m_issued + 32'd1;
  endtask

  task automatic idle(input logic busy);
    cycle(1'b0, mk(m_ld, 32'h0, 32'h0), busy, 1'b0);
  endtask

  initial begin
    bus.enq_valid = 1'b0;
    bus.enq_mop   = mk(m_ld, 32'h0, 32'h0);
    bus.mem_busy  = 1'b0;
    bus.flush     = 1'b0;

    //              ev  busy fl  src0          er  ir  cnt src0_exp      issued
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 0, 32'h0,    32'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h1000, 1'b1, 1'b0, 0, 32'h0,    32'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h1010, 1'b1, 1'b0, 1, 32'h0,    32'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h1020, 1'b1, 1'b0, 2, 32'h0,    32'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'h1030, 1'b1, 1'b0, 3, 32'h0,    32'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'h1040, 1'b0, 1'b0, 4, 32'h0,    32'd0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h1050, 1'b0, 1'b1, 4, 32'h1000, 32'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 3, 32'h1010, 32'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 2, 32'h1020, 32'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1, 32'h1030, 32'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 0, 32'h0,    32'd4};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h2000, 1'b1, 1'b0, 0, 32'h0,    32'd4};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h2010, 1'b1, 1'b0, 1, 32'h0,    32'd4};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 32'h2020, 1'b1, 1'b0, 2, 32'h0,    32'd4};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 32'h2030, 1'b1, 1'b0, 3, 32'h0,    32'd4};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 0, 32'h0,    32'd4};

    // Asynchronous reset with no clock edge in between.
    #1 reset = 1'b0;
    #2;
    check("reset_count", bus.count, 0);
    check("reset_issue_ready", bus.issue_ready, 1'b0);
    check("reset_enq_ready", bus.enq_ready, 1'b1);
    check("reset_issued_cnt", bus.issued_cnt, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].ev, mk(m_st, tbl[i].src0, 32'(i)), tbl[i].busy, tbl[i].fl);
      check($sformatf("tbl%0d_enq_ready", i), obs_er, tbl[i].exp_er);
      check($sformatf("tbl%0d_issue_ready", i), obs_ir, tbl[i].exp_ir);
      check($sformatf("tbl%0d_count", i), obs_cnt, tbl[i].exp_cnt);
      check($sformatf("tbl%0d_issued_cnt", i), obs_iss, tbl[i].exp_issued);
      if (tbl[i].exp_ir) check($sformatf("tbl%0d_issue_src0", i), obs_mop.src0, tbl[i].exp_src0);
    end

    // Single load into an empty, idle queue.
    cycle(1'b1, mk(m_ld, 32'h1000, 32'h0), 1'b0, 1'b0);
`ifdef MEM_ISSUE_QUEUE_BYPASS_EN
    check("ld_bypass_issue_ready", obs_ir, 1'b1);
    check("ld_bypass_src0", obs_mop.src0, 32'h1000);
    idle(1'b0);
    check("ld_bypass_count_after", obs_cnt, 0);
    check("ld_bypass_issued", obs_iss, 32'd5);
`else
    check("ld_same_cycle_no_issue", obs_ir, 1'b0);
    idle(1'b0);
    check("ld_issue_ready", obs_ir, 1'b1);
    check("ld_issue_op", obs_mop.op, m_ld);
    check("ld_issue_src0", obs_mop.src0, 32'h1000);
    check("ld_count_before_pop", obs_cnt, 1);
    idle(1'b0);
    check("ld_count_after_pop", obs_cnt, 0);
    check("ld_issued", obs_iss, 32'd5);
`endif

    // Counter wrap: preset to all-ones, then one issue.
    #1 force dut.issued_total = 32'hFFFF_FFFF;
    #1 release dut.issued_total;
    m_issued = 32'hFFFF_FFFF;
    cycle(1'b1, mk(m_clflush, 32'h3000, 32'h0), 1'b1, 1'b0);
    check("wrap_preset", obs_iss, 32'hFFFF_FFFF);
    idle(1'b0);
    check("wrap_issue_ready", obs_ir, 1'b1);
    idle(1'b0);
    check("wrap_to_zero", obs_iss, 32'd0);

    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7,
            mk(mem_op_e'($urandom_range(0, 2)), $urandom, $urandom),
            $urandom_range(0, 9) < 4,
            $urandom_range(0, 39) == 0);
    end

    // Mid-stream reset with a non-empty queue and the pipeline free.
    cycle(1'b1, mk(m_st, 32'h4000, 32'h1), 1'b1, 1'b0);
    cycle(1'b1, mk(m_st, 32'h4010, 32'h2), 1'b1, 1'b0);
    @(negedge clk);
    bus.enq_valid = 1'b0;
    bus.mem_busy  = 1'b0;
    bus.flush     = 1'b0;
    #1;
    check("pre_reset_issue_ready", bus.issue_ready, 1'b1);
    reset = 1'b0;
    #1;
    check("midreset_count", bus.count, 0);
    check("midreset_issue_ready", bus.issue_ready, 1'b0);
    check("midreset_enq_ready", bus.enq_ready, 1'b1);
    check("midreset_issued_cnt", bus.issued_cnt, 32'd0);
    mq.delete();
    m_issued = '0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 40; i++) begin
      cycle($urandom_range(0, 9) < 6,
            mk(mem_op_e'($urandom_range(0, 2)), $urandom, $urandom),
            $urandom_range(0, 9) < 3,
            1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_issue_queue.md
MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enq_valid  input  1  upstream offers a memory micro-op this cycle.
REQ-005 SHALL have port enq_mop  input  DecoderTypes::micro_op_t  offered micro-op (m_ld, m_st, m_clflush).
REQ-006 SHALL have port enq_ready  output  1  queue can accept; enqueue occurs when enq_valid && enq_ready.
REQ-007 SHALL have port mem_busy  input  1  memory pipeline busy indication; no issue while high.
REQ-008 SHALL have port flush  input  1  discard all queued entries.
REQ-009 SHALL have port issue_ready  output  1  one-cycle issue strobe to the memory pipeline in_ready.
REQ-010 SHALL have port issue_mop  output  DecoderTypes::micro_op_t  micro-op issued, valid when issue_ready.
REQ-011 SHALL have port count  output  $clog2(DEPTH)+1  current number of occupied entries.
REQ-012 SHALL have port issued_cnt  output  32  running total of issued micro-ops.

Function
REQ-013 SHALL store micro-ops in a circular buffer of DEPTH entries with read/write pointers wrapping modulo DEPTH.
REQ-014 SHALL drive enq_ready = (count != DEPTH); an issue in the same cycle does not free a slot for a full-queue enqueue.
REQ-015 SHALL drive issue_ready = (count != 0) && !mem_busy && !flush, combinationally.
REQ-016 SHALL drive issue_mop from the head entry at all times; its value is meaningful only when issue_ready.
REQ-017 SHALL pop the head entry on every cycle issue_ready is high; strictly in-order issue.
REQ-018 SHALL make an enqueued entry visible at the head no earlier than the cycle after enqueue (latency 1, empty to issue).
REQ-019 SHALL on simultaneous enqueue and issue with 0 < count < DEPTH, keep count unchanged and advance both pointers.
REQ-020 SHALL on flush, at the next edge set count to 0 and both pointers to 0, ignoring any same-cycle enqueue; flush has priority over enqueue and issue.
REQ-021 SHALL increment issued_cnt by 1 per issue_ready cycle, wrapping from 0xFFFFFFFF to 0; flush does not clear it.
REQ-022 SHALL never underflow or overflow count; enq_valid while full is ignored without state change.

Reset
REQ-023 SHALL on reset low, immediately and independent of clk, clear count, pointers and issued_cnt to 0.
REQ-024 SHALL hold issue_ready 0 and enq_ready 1 while reset is low and after release until the first enqueue; entry contents are not reset.
REQ-025 SHALL resume normal operation at the first rising clk edge after reset goes high; reset mid-operation discards all entries.

Configuration
REQ-026 SHALL implement bypass when macro MEM_ISSUE_QUEUE_BYPASS_EN is defined: with count == 0, !mem_busy, !flush and enq_valid, issue_ready asserts in the same cycle with issue_mop = enq_mop, the entry is not written, and issued_cnt increments.
REQ-027 SHALL, without MEM_ISSUE_QUEUE_BYPASS_EN, have no combinational path from enq_valid/enq_mop to issue_ready/issue_mop.

Verification
REQ-028 SHALL cover: enqueue m_ld (src0=0x1000) into empty queue, mem_busy=0 -> issue_ready high exactly 1 cycle later with that mop, count 1->0, issued_cnt=1 (bypass off); same cycle with bypass on.
REQ-029 SHALL cover: mem_busy=1, enqueue 5 mops with DEPTH=4 -> first 4 accepted, enq_ready=0 on 5th, count=4; drop mem_busy -> 4 issues in order, one per cycle.
REQ-030 SHALL cover: count=4, enq_valid and issue same cycle -> enqueue rejected, count=3 next cycle.
REQ-031 SHALL cover: count=3 with flush and enq_valid asserted together -> count=0 next cycle, no issue that cycle, issued_cnt unchanged.
REQ-032 SHALL cover: 10 enqueue/issue cycles crossing pointer wrap -> issue order equals enqueue order; reset asserted mid-stream -> count=0, issue_ready=0 immediately, without a clock edge.
REQ-033 SHALL cover: issued_cnt preset via 2^32 issues (or forced) at 0xFFFFFFFF -> next issue yields 0.
